// File: rtl/instructions_pkg.sv
// Shared ICU instruction encoding plus sequencer sizing defaults and the
// program-word layout stored in program memory.
package instructions;

  localparam int PROG_ADDR_W_DEFAULT  = 8;
  localparam int RSTACK_DEPTH_DEFAULT = 4;

  typedef enum logic [3:0] {
    NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } instruction_t;

  typedef struct packed {
    instruction_t                   opcode;
    logic [PROG_ADDR_W_DEFAULT-1:0] target;
  } prog_word_t;

  function automatic prog_word_t make_word(instruction_t op,
                                           logic [PROG_ADDR_W_DEFAULT-1:0] target);
    prog_word_t w;
    w.opcode = op;
    w.target = target;
    return w;
  endfunction

endpackage

// File: rtl/sequencer_if.sv
// Program-memory bus and ICU request/acknowledge handshake seen by the sequencer.
interface sequencer_if
  import instructions::*;
#(
  parameter int ADDR_W = PROG_ADDR_W_DEFAULT
);
  logic [ADDR_W-1:0]   rom_addr;
  logic [ADDR_W+3:0]   rom_data;
  instruction_t        instruction;
  logic                req_next;
  logic                ack_next;
  logic                jmp;
  logic                rtn;
  logic                flag_f;

  modport master (
    output rom_addr, instruction, req_next,
    input  rom_data, ack_next, jmp, rtn, flag_f
  );

  modport slave (
    input  rom_addr, instruction, req_next,
    output rom_data, ack_next, jmp, rtn, flag_f
  );
endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses; pushes on full and pops on empty are ignored and
// the caller decides how to flag them.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] data,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] top_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = IW'(count - CW'(1));
  assign data    = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // NOTE: storage is not reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[IW'(count)] <= push_data;
    end
  end

endmodule

// File: rtl/sequencer.sv
// Program sequencer for the ICU: fetches {opcode,target} words, runs the
// req/ack handshake and steers the pc from the ICU's jmp/rtn/flag_f results.
module sequencer
  import instructions::*;
#(
  parameter int PROG_ADDR_W  = PROG_ADDR_W_DEFAULT,
  parameter int RSTACK_DEPTH = RSTACK_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  sequencer_if.master      bus,
  output logic             halted,
  output logic             stack_err
);
  typedef enum logic [2:0] {
    IDLE, FETCH, ROMWAIT, ISSUE, EXEC, RELEASE, HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [PROG_ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [PROG_ADDR_W-1:0] target_q, rom_addr_q, stk_top;
  instruction_t           instr_q;
  logic                   flag_q, run_q, err_d;
  logic                   push, pop, stk_full, stk_empty;

  assign pc_inc = pc_q + PROG_ADDR_W'(1);

  return_stack #(
    .DEPTH (RSTACK_DEPTH),
    .W     (PROG_ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .data      (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_d   = stack_err;
    case (state_q)
      IDLE:    if (run) state_d = FETCH;
      FETCH:   state_d = ROMWAIT;
      ROMWAIT: state_d = ISSUE;
      ISSUE:   if (bus.ack_next) state_d = EXEC;
      EXEC: begin
        state_d = RELEASE;
        // jmp has priority over rtn; a jump is taken even if its return is lost
        if (bus.jmp) begin
          push = 1'b1;
          pc_d = target_q;
          if (stk_full) err_d = 1'b1;
        end else if (bus.rtn) begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end else begin
          pc_d = pc_inc;
        end
      end
      RELEASE: begin
        if (!bus.ack_next) begin
          if (flag_q)   state_d = HALT;
          else if (run) state_d = FETCH;
          else          state_d = IDLE;
        end
      end
      HALT:    if (run && !run_q) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      rom_addr_q <= '0;
      instr_q    <= NOPO;
      target_q   <= '0;
      flag_q     <= 1'b0;
      run_q      <= 1'b0;
      stack_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      run_q     <= run;
      stack_err <= err_d;
      if (state_d == FETCH) rom_addr_q <= pc_q;
      if (state_q == ROMWAIT) begin
        instr_q  <= instruction_t'(bus.rom_data[PROG_ADDR_W +: 4]);
        target_q <= bus.rom_data[PROG_ADDR_W-1:0];
      end
      if (state_q == EXEC) flag_q <= bus.flag_f;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.instruction = instr_q;
  assign bus.req_next    = (state_q == ISSUE) || (state_q == EXEC);
  assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench: ICU/ROM behavioural model with a pc/return-stack
// reference computed per instruction from the sequencing rules.
module tb_sequencer;
  import instructions::*;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, run, halted, stack_err;
  logic ack_drv, echo;
  int   checks = 0, failures = 0, cyc = 0, last_issue = 0;

  logic [11:0] rom [256];
  logic [7:0]  pc_m;
  logic [7:0]  stk_m [$];
  logic        err_m;

  sequencer_if #(.ADDR_W(AW)) bus();

  sequencer #(.PROG_ADDR_W(AW), .RSTACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bus       (bus),
    .halted    (halted),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  assign bus.ack_next = echo ? bus.req_next : ack_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_req(input logic level, input int limit);
    int n = 0;
    while (bus.req_next !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_next !== level) check("req_wait", bus.req_next, level);
  endtask

  task automatic model_reset();
    pc_m  = 8'h00;
    err_m = 1'b0;
    stk_m.delete();
  endtask

  // One complete instruction as the ICU sees it, with the reference update.
  task automatic do_instr(input bit j, input bit r, input bit f,
                          input int ack_dly, input int rel_dly, input bit chk_per);
    logic [7:0]  fetch;
    logic [11:0] word;
    int n;
    wait_req(1'b1, 40);
    fetch = pc_m;
    word  = rom[fetch];
    check("rom_addr", bus.rom_addr, fetch);
    check("opcode", bus.instruction, word[11:8]);
    if (chk_per) check("period", cyc - last_issue, 5);
    last_issue = cyc;
    bus.jmp = j; bus.rtn = r; bus.flag_f = f;
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      check("req_hold", bus.req_next, 1);
    end
    ack_drv = 1'b1;
    @(negedge clk);
    check("opcode_exec", bus.instruction, word[11:8]);
    wait_req(1'b0, 10);

    if (j) begin
      if (stk_m.size() < DEPTH) stk_m.push_back(8'(fetch + 8'd1));
      else err_m = 1'b1;
      pc_m = word[7:0];
    end else if (r) begin
      if (stk_m.size() == 0) begin
        err_m = 1'b1;
        pc_m  = 8'(fetch + 8'd1);
      end else begin
        pc_m = stk_m.pop_back();
      end
    end else begin
      pc_m = 8'(fetch + 8'd1);
    end

    check("stack_err", stack_err, err_m);
    check("opcode_release", bus.instruction, word[11:8]);
    repeat (rel_dly) @(negedge clk);
    ack_drv = 1'b0;
    if (f) begin
      n = 0;
      while (!halted && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("halted", halted, 1);
      repeat (3) @(negedge clk);
      check("halt_rom_addr", bus.rom_addr, fetch);
      check("halt_hold", halted, 1);
      run = 1'b0;
      @(negedge clk);
      run = 1'b1;
    end else begin
      check("not_halted", halted, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; ack_drv = 1'b0; echo = 1'b1;
    bus.jmp = 1'b0; bus.rtn = 1'b0; bus.flag_f = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    rom[8'h00] = make_word(LD,   8'h11);
    rom[8'h01] = make_word(OR,   8'h22);
    rom[8'h02] = make_word(STO,  8'h33);
    rom[8'h03] = make_word(JMP,  8'h40);
    rom[8'h40] = make_word(RTN,  8'h00);
    rom[8'h04] = make_word(JMP,  8'h50);
    rom[8'h50] = make_word(JMP,  8'h60);
    rom[8'h60] = make_word(JMP,  8'h70);
    rom[8'h70] = make_word(JMP,  8'h80);
    rom[8'h80] = make_word(JMP,  8'h90);
    rom[8'h06] = make_word(JMP,  8'hFE);
    rom[8'hFE] = make_word(NOPF, 8'h00);
    rom[8'hFF] = make_word(NOPO, 8'h00);
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_req", bus.req_next, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_instr", bus.instruction, NOPO);
    check("rst_halted", halted, 0);
    check("rst_stack_err", stack_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_req", bus.req_next, 0);
    run = 1'b1;

    // Directed program with same-cycle ack echo
    do_instr(0, 0, 0, 0, 0, 0);
    do_instr(0, 0, 0, 0, 0, 1);
    do_instr(0, 0, 0, 0, 0, 1);
    do_instr(1, 0, 0, 0, 0, 1);
    do_instr(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) do_instr(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) do_instr(0, 1, 0, 0, 0, 1);
    do_instr(1, 0, 0, 0, 0, 1);
    do_instr(0, 0, 1, 0, 0, 1);
    do_instr(0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc_m, 8'h00);
    do_instr(0, 0, 0, 0, 0, 1);

    // Randomised flags and handshake delays
    echo = 1'b0;
    for (int i = 0; i < 150; i++) begin
      do_instr($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 3),
               $urandom_range(0, 3), 0);
    end

    // Reset in the middle of ISSUE
    ack_drv = 1'b0;
    wait_req(1'b1, 40);
    rst = 1'b1;
    #1;
    check("mid_rst_req", bus.req_next, 0);
    check("mid_rst_instr", bus.instruction, NOPO);
    check("mid_rst_err", stack_err, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    ack_drv = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_req", bus.req_next, 0);
    check("post_rst_rom_addr", bus.rom_addr, 0);
    ack_drv = 1'b0;
    model_reset();
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_instr($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0,
               $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
